div_hilo_unit: RTL and testbench

- Multi-cycle signed 32-bit divider that produces the division results the HI/LO write path consumes: the remainder goes to HI and the quotient goes to LO.
- It sits beside the multiplier in the execute stage. The main control FSM starts it, then waits for `done` before selecting the divider output for the HI/LO registers.
- It uses a restoring shift-subtract algorithm on magnitudes, one quotient bit per cycle, followed by a sign-fix step.

---
 rtl/div_hilo_unit.sv | 131 +++++++++++++
 tb/tb_div_hilo_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/div_hilo_unit.sv
// rtl/div_hilo_unit.sv - signed restoring divider feeding HI (remainder) and LO (quotient)
module div_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             divZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_ZERO = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             done_q, done_d;
  logic             divz_q, divz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Shifted remainder kept at WIDTH+1 bits so a 0x80000000 divisor magnitude still compares correctly
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;

  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    done_d  = 1'b0;
    divz_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            quo_d   = dividend[WIDTH-1] ? -dividend : dividend;
            dvs_d   = divisor[WIDTH-1] ? -divisor : divisor;
            rem_d   = '0;
            cnt_d   = '0;
            negq_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            negr_d  = dividend[WIDTH-1];
            state_d = S_CALC;
          end else begin
            state_d = S_ZERO;
          end
        end
      end
      S_CALC: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        lo_d    = negq_q ? -quo_q : quo_q;
        hi_d    = negr_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        divz_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      done_q  <= done_d;
      divz_q  <= divz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy    = (state_q == S_CALC) || (state_q == S_FIX);
  assign done    = done_q;
  assign divZero = divz_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_div_hilo_unit.sv
// tb/tb_div_hilo_unit.sv - self-checking bench for div_hilo_unit against an arithmetic model
module tb_div_hilo_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        divZero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  div_hilo_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .divZero  (divZero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Quotient truncates toward zero, remainder follows the dividend; -2^31 / -1 wraps
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int poke_at,
                         input string tag, output logic [31:0] q_out, output logic [31:0] r_out);
    logic [31:0] eq;
    logic [31:0] er;
    int k;
    int bcnt;
    ref_div(a, b, eq, er);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    k    = 0;
    bcnt = busy ? 1 : 0;
    while (!done && k < 100) begin
      if (k == poke_at) begin
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd3;
      end else begin
        start = 1'b0;
      end
      tick();
      k++;
      if (busy) bcnt++;
    end
    start = 1'b0;
    check({tag, "_latency"}, k, 33);
    check({tag, "_busy_cycles"}, bcnt, 33);
    check({tag, "_lo"}, lo, eq);
    check({tag, "_hi"}, hi, er);
    q_out = lo;
    r_out = hi;
  endtask

  initial begin
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] a;
    logic [31:0] b;
    int dcnt;

    reset    = 1'b1;
    start    = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;
    tick();
    tick();
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_divzero", divZero, 0);
    reset = 1'b0;
    tick();

    run_div(32'd100, 32'd7, -1, "pos", q, r);
    check("pos_lo_const", q, 32'd14);
    check("pos_hi_const", r, 32'd2);
    check("pos_done_pulse", done, 1);
    tick();
    check("pos_done_drop", done, 0);

    run_div(-32'sd100, 32'd7, -1, "negdvd", q, r);
    check("negdvd_lo_const", q, 32'hFFFF_FFF2);
    check("negdvd_hi_const", r, 32'hFFFF_FFFE);
    run_div(32'd100, -32'sd7, -1, "negdvs", q, r);
    check("negdvs_lo_const", q, -32'sd14);
    check("negdvs_hi_const", r, 32'd2);
    run_div(-32'sd100, -32'sd7, -1, "negboth", q, r);
    check("negboth_lo_const", q, 32'd14);
    check("negboth_hi_const", r, -32'sd2);
    tick();

    run_div(32'd100, 32'd7, -1, "pre_dz", q, r);
    tick();
    start    = 1'b1;
    dividend = 32'd55;
    divisor  = 32'd0;
    tick();
    start = 1'b0;
    check("dz_after_accept", divZero, 0);
    check("dz_busy", busy, 0);
    tick();
    check("dz_pulse", divZero, 1);
    tick();
    check("dz_pulse_end", divZero, 0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dcnt++;
    end
    check("dz_no_done", dcnt, 0);
    check("dz_hi_kept", hi, 32'd2);
    check("dz_lo_kept", lo, 32'd14);

    run_div(32'h8000_0000, 32'hFFFF_FFFF, -1, "ovf", q, r);
    check("ovf_lo_const", q, 32'h8000_0000);
    check("ovf_hi_const", r, 32'h0);
    run_div(32'd5, 32'd9, -1, "small", q, r);
    check("small_lo_const", q, 32'd0);
    check("small_hi_const", r, 32'd5);
    run_div(32'hFFFF_FFFF, 32'd1, -1, "neg1", q, r);
    check("neg1_lo_const", q, 32'hFFFF_FFFF);
    check("neg1_hi_const", r, 32'h0);
    run_div(32'h8000_0000, 32'h8000_0000, -1, "minmin", q, r);
    tick();

    run_div(32'd12345, 32'd67, 10, "poke", q, r);
    check("b2b_done_high", done, 1);
    run_div(32'd999, -32'sd13, -1, "b2b", q, r);
    tick();

    start    = 1'b1;
    dividend = 32'd1_000_000;
    divisor  = 32'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_hi", hi, 0);
    check("rst_mid_lo", lo, 0);
    check("rst_mid_busy", busy, 0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dcnt++;
    end
    check("rst_mid_no_done", dcnt, 0);
    run_div(32'd81, 32'd9, -1, "post_rst", q, r);
    check("post_rst_lo_const", q, 32'd9);
    check("post_rst_hi_const", r, 32'd0);

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      if (i % 2 == 0) begin
        b = $urandom;
      end else begin
        b = $urandom_range(1, 1000);
        if ($urandom_range(0, 1) == 1) b = -b;
      end
      if (b == 32'd0) b = 32'd1;
      run_div(a, b, -1, $sformatf("rand%0d", i), q, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
